// File: rtl/field_pkg.sv
// Shared field-memory layout and constants for the field writer/reader pair.
package field_pkg;

  localparam int unsigned FIELD_WIDTH  = 8;
  localparam int unsigned FIELD_HEIGHT = 6;
  localparam int unsigned FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT;
  localparam int unsigned FIELD_ADDRW  = $clog2(FIELD_SIZE);
  localparam int unsigned FIELD_DATAW  = 96;
  localparam int unsigned FIELD_XW     = $clog2(FIELD_WIDTH);
  localparam int unsigned FIELD_YW     = $clog2(FIELD_HEIGHT);
  localparam int unsigned FIX_W        = 32;

  // Q16.16 signed fixed point
  typedef logic signed [FIX_W-1:0] fix_t;

  // Memory word: xn in [95:64], yn in [63:32], mag in [31:0]
  typedef struct packed {
    fix_t             xn;
    fix_t             yn;
    logic [FIX_W-1:0] mag;
  } field_elem_t;

endpackage

// File: rtl/field_skid_fifo.sv
// Small shift-register FIFO; the head entry is always slot 0 so dout is a flop.
module field_skid_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic [CNTW-1:0]  cnt_n;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[0];

  // Next storage image: shift out the head on pop, then append at the tail
  always_comb begin
    mem_n = mem;
    cnt_n = count;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_n[i] = mem[i+1];
      end
      mem_n[DEPTH-1] = '0;
      cnt_n = count - CNTW'(1);
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_n == CNTW'(i)) begin
          mem_n[i] = din;
        end
      end
      cnt_n = cnt_n + CNTW'(1);
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      count <= '0;
    end else begin
      mem   <= mem_n;
      count <= cnt_n;
    end
  end

endmodule

// File: rtl/field_reader.sv
// Raster-order reader of the field memory, streaming unpacked entries over valid/ready.
module field_reader
  import field_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   field_re,
  output logic [FIELD_ADDRW-1:0] field_addr_read,
  input  logic [FIELD_DATAW-1:0] field_data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FIELD_XW-1:0]    out_x,
  output logic [FIELD_YW-1:0]    out_y,
  output fix_t                   out_xn,
  output fix_t                   out_yn,
  output logic [FIX_W-1:0]       out_mag,
  output logic                   out_last
);

  localparam int unsigned FIFO_DEPTH = READ_LATENCY + 1;
  localparam int unsigned CNTW       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                   state;
  logic [READ_LATENCY-1:0]  tag_sr;
  logic [CNTW-1:0]          fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [FIELD_DATAW-1:0]   fifo_dout;
  field_elem_t              head;
  int unsigned              inflight;
  logic [FIELD_XW-1:0]      beat_x_n;
  logic [FIELD_YW-1:0]      beat_y_n;
  logic                     beat_last_n;

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = tag_sr[READ_LATENCY-1];
  assign head      = field_elem_t'(fifo_dout);
  assign out_xn    = head.xn;
  assign out_yn    = head.yn;
  assign out_mag   = head.mag;

  // Credit check: a new read is allowed only if its data is guaranteed a FIFO slot
  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + 32'(tag_sr[i]);
    end
    field_re = (state == S_ISSUE) &&
               ((32'(fifo_count) + inflight) < (FIFO_DEPTH + 32'(fifo_pop)));
  end

  // Output-side raster position following the beat just accepted
  always_comb begin
    beat_x_n = out_x + FIELD_XW'(1);
    beat_y_n = out_y;
    if (out_x == FIELD_XW'(FIELD_WIDTH - 1)) begin
      beat_x_n = '0;
      beat_y_n = (out_y == FIELD_YW'(FIELD_HEIGHT - 1)) ? '0 : out_y + FIELD_YW'(1);
    end
    beat_last_n = (beat_x_n == FIELD_XW'(FIELD_WIDTH - 1)) &&
                  (beat_y_n == FIELD_YW'(FIELD_HEIGHT - 1));
  end

  // Tags marking which cycles carry returned read data
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_sr <= '0;
    end else begin
      tag_sr[0] <= field_re;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  // Scan sequencer, issue address and beat position
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      field_addr_read <= '0;
      out_x           <= '0;
      out_y           <= '0;
      out_last        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (field_re) begin
        field_addr_read <= field_addr_read + FIELD_ADDRW'(1);
      end
      if (fifo_pop) begin
        out_x    <= beat_x_n;
        out_y    <= beat_y_n;
        out_last <= beat_last_n;
      end
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            state           <= S_ISSUE;
            busy            <= 1'b1;
            field_addr_read <= '0;
            out_x           <= '0;
            out_y           <= '0;
            out_last        <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (field_re && (field_addr_read == FIELD_ADDRW'(FIELD_SIZE - 1))) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_pop && out_last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The credit rule must never let returned data arrive at a full FIFO
  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));

  field_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIELD_DATAW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (field_data_out),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_field_reader.sv
// Directed bench for field_reader at read latencies 1 and 3.
module tb_field_reader;
  import field_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ready;
  logic sel;

  int n_tests = 0;
  int n_fail  = 0;

  // latency-1 instance signals
  logic        busy0, done0, re0, valid0, last0;
  logic [5:0]  addr0;
  logic [95:0] data0;
  logic [2:0]  x0, y0;
  logic [31:0] xn0, yn0, mag0;
  // latency-3 instance signals
  logic        busy3, done3, re3, valid3, last3;
  logic [5:0]  addr3;
  logic [95:0] data3;
  logic [2:0]  x3, y3;
  logic [31:0] xn3, yn3, mag3;

  logic [95:0] mem [48];
  logic [95:0] pipe0;
  logic [95:0] pipe3 [3];

  // observed view of the selected instance
  logic        o_busy, o_done, o_re, o_valid, o_last;
  logic [5:0]  o_addr;
  logic [2:0]  o_x, o_y;
  logic [95:0] o_data;

  assign o_busy  = sel ? busy3  : busy0;
  assign o_done  = sel ? done3  : done0;
  assign o_re    = sel ? re3    : re0;
  assign o_valid = sel ? valid3 : valid0;
  assign o_last  = sel ? last3  : last0;
  assign o_addr  = sel ? addr3  : addr0;
  assign o_x     = sel ? x3     : x0;
  assign o_y     = sel ? y3     : y0;
  assign o_data  = sel ? {xn3, yn3, mag3} : {xn0, yn0, mag0};

  always #5 clk = ~clk;

  field_reader #(.READ_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .start(start && !sel), .busy(busy0), .done(done0),
    .field_re(re0), .field_addr_read(addr0), .field_data_out(data0),
    .out_valid(valid0), .out_ready(ready), .out_x(x0), .out_y(y0),
    .out_xn(xn0), .out_yn(yn0), .out_mag(mag0), .out_last(last0)
  );

  field_reader #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start && sel), .busy(busy3), .done(done3),
    .field_re(re3), .field_addr_read(addr3), .field_data_out(data3),
    .out_valid(valid3), .out_ready(ready), .out_x(x3), .out_y(y3),
    .out_xn(xn3), .out_yn(yn3), .out_mag(mag3), .out_last(last3)
  );

  function automatic logic [95:0] word_of(input int i);
    if (i == 13) return {32'hFFFF0000, 32'h00018000, 32'h00020000};
    return {32'(i), 32'(i) << 16, 32'(i) << 8};
  endfunction

  initial begin
    for (int i = 0; i < 48; i++) mem[i] = word_of(i);
  end

  // field memory models; non-read cycles return junk that must be ignored
  always @(posedge clk) begin
    pipe0    <= re0 ? mem[addr0] : {$urandom, $urandom, $urandom};
    pipe3[0] <= re3 ? mem[addr3] : {$urandom, $urandom, $urandom};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign data0 = pipe0;
  assign data3 = pipe3[2];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_re"}, o_re, 0);
    check({tag, "_addr"}, o_addr, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_xy"}, {o_x, o_y}, 0);
    check({tag, "_data"}, o_data, 0);
  endtask

  // mode 0: ready high; mode 1: ready low for stall_len cycles from first beat; mode 2: random ready
  task automatic run_scan(input bit s, input int mode, input int stall_len,
                          input bit extra_starts, input bit start_on_done);
    int k, issued, dones, first_v, last_v, last_re, stall_left, lat, depth;
    bit hold, ended;
    logic [95:0] held_d, w;
    logic [6:0]  held_p;
    lat = s ? 3 : 1;
    depth = lat + 1;
    sel = s;
    k = 0; issued = 0; dones = 0; first_v = -1; last_v = -1; last_re = -1;
    stall_left = stall_len; hold = 0; ended = 0;
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    for (int cyc = 1; cyc < 400 && !ended; cyc++) begin
      @(negedge clk);
      start = extra_starts && (cyc == 5 || cyc == 20);
      case (mode)
        1: begin
          if ((first_v >= 0 || o_valid) && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
          end else begin
            ready = 1'b1;
          end
        end
        2: ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
      #1;
      check("done", o_done, k == 48);
      check("busy", o_busy, k != 48);
      if (o_done) dones++;
      if (k == 48) begin
        ended = 1;
        if (start_on_done) start = 1'b1;
      end
      if (o_re) begin
        check("addr", o_addr, issued);
        if (issued == 0) check("first_re_cycle", cyc, 1);
        issued++;
        last_re = cyc;
      end
      check("outstanding", (issued - k - ((o_valid && ready) ? 1 : 0)) <= depth, 1);
      if (hold) begin
        check("valid_held", o_valid, 1);
        check("hold_data", o_data, held_d);
        check("hold_pos", {o_x, o_y, o_last}, held_p);
      end
      if (o_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          check("first_valid_cycle", cyc, 2 + lat);
        end
        w = word_of(k);
        check("beat_x", o_x, k % 8);
        check("beat_y", o_y, k / 8);
        check("beat_data", o_data, w);
        check("beat_last", o_last, k == 47);
        if (k == 13) begin
          check("unpack_x", o_x, 5);
          check("unpack_y", o_y, 1);
          check("unpack_xn", o_data[95:64], 32'hFFFF0000);
          check("unpack_yn", o_data[63:32], 32'h00018000);
          check("unpack_mag", o_data[31:0], 32'h00020000);
        end
        if (ready) begin
          k++;
          hold = 0;
          last_v = cyc;
        end else begin
          hold = 1;
          held_d = o_data;
          held_p = {o_x, o_y, o_last};
        end
      end
    end
    check("beats_total", k, 48);
    check("reads_total", issued, 48);
    if (mode == 0) begin
      check("full_rate_last_beat", last_v, first_v + 47);
      check("last_re_cycle", last_re, 48);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (o_done) dones++;
      check("after_busy", o_busy, 0);
      check("after_re", o_re, 0);
      check("after_valid", o_valid, 0);
    end
    check("done_count", dones, 1);
  endtask

  task automatic run_reset_mid();
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_rst_valid", o_valid, 1);
    check("pre_rst_x", o_x, 4);
    check("pre_rst_y", o_y, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("mid_rst");
    @(negedge clk);
    #1;
    check("mid_rst_stay_valid", o_valid, 0);
    check("mid_rst_stay_re", o_re, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("rst_l1");
    sel = 1'b1;
    #1;
    check_idle("rst_l3");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_scan(1'b0, 0, 0, 1'b0, 1'b0);
    run_scan(1'b0, 1, 10, 1'b0, 1'b0);
    run_scan(1'b0, 2, 0, 1'b0, 1'b0);
    run_scan(1'b0, 0, 0, 1'b1, 1'b1);
    run_reset_mid();
    run_scan(1'b0, 0, 0, 1'b0, 1'b0);
    run_scan(1'b1, 0, 0, 1'b0, 1'b0);
    run_scan(1'b1, 1, 10, 1'b0, 1'b0);
    run_scan(1'b1, 2, 0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
